// File: rtl/syzygy_adc_pkg.sv
// rtl/syzygy_adc_pkg.sv - state type and defaults for the SYZYGY ADC encode controller
package syzygy_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } adc_enc_state_t;

  localparam int unsigned ADC_ENC_WARMUP_DEFAULT = 16;

endpackage

// File: rtl/syzygy_adc_enc_ctrl.sv
// rtl/syzygy_adc_enc_ctrl.sv - ADC encode-clock gating, warmup and sample-burst sequencer
// SYZYGY_ADC_ENC_CTRL_FREE_RUN_EN: keep encode running from reset, warm up once, bursts skip WARMUP
import syzygy_adc_pkg::*;

module syzygy_adc_enc_ctrl #(
  parameter int unsigned WARMUP_CYCLES = ADC_ENC_WARMUP_DEFAULT,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [COUNT_W-1:0] burst_len,
  output logic               enc_en,
  output logic               sample_valid,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] sample_count
);

  localparam logic [15:0]        WARM_LAST = 16'(WARMUP_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  adc_enc_state_t     state_q, state_d;
  logic [15:0]        warm_cnt_q, warm_cnt_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               enc_en_q, enc_en_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               warmed_q, warmed_d;

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    len_d      = len_q;
    count_d    = count_q;
    warmed_d   = warmed_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef SYZYGY_ADC_ENC_CTRL_FREE_RUN_EN
        if (!warmed_q) begin
          state_d    = WARMUP;
          warm_cnt_d = '0;
        end else if (start && !stop) begin
          len_d   = burst_len;
          count_d = CNT_ONE;
          valid_d = 1'b1;
          state_d = CAPTURE;
        end
`else
        if (start && !stop) begin
          len_d      = burst_len;
          count_d    = '0;
          warm_cnt_d = '0;
          state_d    = WARMUP;
        end
`endif
      end
      WARMUP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (warm_cnt_q == WARM_LAST) begin
`ifdef SYZYGY_ADC_ENC_CTRL_FREE_RUN_EN
          warmed_d = 1'b1;
          state_d  = IDLE;
`else
          count_d = CNT_ONE;
          valid_d = 1'b1;
          state_d = CAPTURE;
`endif
        end else begin
          warm_cnt_d = warm_cnt_q + 16'd1;
        end
      end
      CAPTURE: begin
        // count_q already includes the valid cycle currently on the output
        if (stop || (len_q != '0 && count_q == len_q)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          valid_d = 1'b1;
          if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
`ifdef SYZYGY_ADC_ENC_CTRL_FREE_RUN_EN
    enc_en_d = 1'b1;
`else
    enc_en_d = (state_d == WARMUP) || (state_d == CAPTURE);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      warm_cnt_q <= '0;
      len_q      <= '0;
      count_q    <= '0;
      warmed_q   <= 1'b0;
      enc_en_q   <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      len_q      <= len_d;
      count_q    <= count_d;
      warmed_q   <= warmed_d;
      enc_en_q   <= enc_en_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign enc_en       = enc_en_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_syzygy_adc_enc_ctrl.sv
// tb/tb_syzygy_adc_enc_ctrl.sv - directed self-checking bench for syzygy_adc_enc_ctrl (WARMUP_CYCLES=4)
module tb_syzygy_adc_enc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] burst_len = '0;
  logic        enc_en, sample_valid, busy, done;
  logic [15:0] sample_count;

  int errors = 0;
  int checks = 0;

  syzygy_adc_enc_ctrl #(.WARMUP_CYCLES(4), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .burst_len(burst_len),
    .enc_en(enc_en), .sample_valid(sample_valid), .busy(busy), .done(done),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] m_valid, m_done, m_en, m_busy;
    logic [15:0] cnt_done;
    int nv, k_last_valid, k_done;
    logic any_done, any_valid, seen;

    tick(); tick(); tick();
    chk("reset_outputs", {enc_en, sample_valid, busy, done}, 4'b0000);
    chk("reset_count", sample_count, 16'd0);
    reset = 1'b0;
    tick();

`ifdef SYZYGY_ADC_ENC_CTRL_FREE_RUN_EN
    chk("fr_enc_en_after_reset", enc_en, 1'b1);
    chk("fr_busy_warmup", busy, 1'b1);
    start = 1'b1; burst_len = 16'd2;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (!busy) seen = 1'b1;
      else tick();
    end
    chk("fr_warmup_ends", seen, 1'b1);
    chk("fr_start_in_warmup_ignored", sample_valid, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fr_first_valid_t1", sample_valid, 1'b1);
    chk("fr_count_t1", sample_count, 16'd1);
    tick();
    chk("fr_second_valid", sample_valid, 1'b1);
    tick();
    chk("fr_done", {done, sample_valid, enc_en}, 3'b101);
    chk("fr_count_done", sample_count, 16'd2);
    tick();
    chk("fr_idle_enc_en", {busy, enc_en}, 2'b01);
`else
    chk("idle_after_reset", {enc_en, busy}, 2'b00);

    // start together with stop must be ignored
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_with_stop_ignored", busy, 1'b0);

    // finite burst of 3; later burst_len change must not matter
    burst_len = 16'd3; start = 1'b1;
    tick();
    start = 1'b0; burst_len = 16'd7;
    m_valid = '0; m_done = '0; m_en = '0; m_busy = '0; cnt_done = '0;
    for (int k = 1; k <= 12; k++) begin
      m_valid[k] = sample_valid; m_done[k] = done; m_en[k] = enc_en; m_busy[k] = busy;
      if (done) cnt_done = sample_count;
      if (k < 12) tick();
    end
    chk("burst3_valid_mask", m_valid, 32'h0000_00E0);
    chk("burst3_done_mask", m_done, 32'h0000_0100);
    chk("burst3_enc_en_mask", m_en, 32'h0000_00FE);
    chk("burst3_busy_mask", m_busy, 32'h0000_01FE);
    chk("burst3_count", cnt_done, 16'd3);

    // continuous run, stop sampled at the end of the 10th valid cycle
    burst_len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    nv = 0; k_last_valid = -1; k_done = -1; any_done = 1'b0; cnt_done = '0;
    for (int k = 0; k < 100 && !any_done; k++) begin
      if (sample_valid) begin nv++; k_last_valid = k; end
      if (done) begin any_done = 1'b1; k_done = k; cnt_done = sample_count; end
      if (nv == 10) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    chk("cont_done_seen", any_done, 1'b1);
    chk("cont_valid_count", nv, 10);
    chk("cont_done_next_cycle", k_done, k_last_valid + 1);
    chk("cont_sample_count", cnt_done, 16'd10);

    // stop during WARMUP
    burst_len = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("warm_enc_en", enc_en, 1'b1);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("warm_stop_idle", {enc_en, busy, done}, 3'b000);
    chk("warm_stop_count", sample_count, 16'd0);
    any_done = 1'b0; any_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      any_done |= done; any_valid |= sample_valid;
      tick();
    end
    chk("warm_stop_no_done", {any_done, any_valid}, 2'b00);

    // start held high: back-to-back bursts of 2
    burst_len = 16'd2; start = 1'b1;
    tick();
    m_valid = '0; m_done = '0; m_busy = '0;
    for (int k = 1; k <= 16; k++) begin
      m_valid[k] = sample_valid; m_done[k] = done; m_busy[k] = busy;
      if (k == 16) start = 1'b0;
      tick();
    end
    chk("held_valid_mask", m_valid, 32'h0000_6060);
    chk("held_done_mask", m_done, 32'h0000_8080);
    chk("held_busy_mask", m_busy, 32'h0000_FEFE);
    chk("held_idle_after", busy, 1'b0);

    // reset mid-CAPTURE
    burst_len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sample_valid) seen = 1'b1;
      else tick();
    end
    chk("rst_reached_capture", seen, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_outputs", {enc_en, sample_valid, busy, done}, 4'b0000);
    chk("rst_count", sample_count, 16'd0);
    any_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      any_done |= done | busy;
      tick();
    end
    chk("rst_no_done", any_done, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/syzygy_adc_enc_ctrl.md
# syzygy_adc_enc_ctrl

Sequences the ADC encode clock for one SYZYGY ADC channel: gates the encode clock on request, waits out the ADC pipeline/settling latency, then flags a counted burst (or continuous run) of valid sample cycles. Sits between host-side capture control (endpoint triggers/wires) and the encode output buffer path. Its `enc_en` drives the clock-enable of the buffer feeding the encode output. `sample_valid` qualifies the captured data stream.

## Interface
Parameters:
- `WARMUP_CYCLES`, 16: encode cycles discarded after `enc_en` rises (ADC pipeline latency plus settle); legal range 1..65535.
- `COUNT_W`, 16: width of burst length and sample counter.

Ports:
- `clk`  in  1  encode-domain clock; the same clock that is forwarded as the ADC encode.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  capture request; sampled only in IDLE.
- `stop`  in  1  abort/terminate request; level, sampled every cycle.
- `burst_len`  in  COUNT_W  samples per burst; 0 = continuous until `stop`; latched on accepted `start`.
- `enc_en`  out  1  encode clock enable.
- `sample_valid`  out  1  current ADC sample belongs to the burst.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at burst end.
- `sample_count`  out  COUNT_W  valid samples delivered in current/last burst; saturates at all-ones.

## Operation
- States: IDLE, WARMUP, CAPTURE, DONE. All outputs are registered.
- Reset: state IDLE; `enc_en`, `sample_valid`, `busy`, `done` = 0; `sample_count` = 0; counters cleared. Reset mid-burst aborts immediately, with no `done`.
- IDLE: `start`=1 and `stop`=0 -> latch `burst_len`, clear `sample_count`, go WARMUP. `start` with `stop` both high -> ignored.
- WARMUP: `enc_en`=1; count WARMUP_CYCLES cycles; then go CAPTURE. `stop` -> IDLE with no `done`; `sample_count` stays 0.
- CAPTURE: `enc_en`=1, `sample_valid`=1, `sample_count` increments each cycle.
  - Finite burst: leave after exactly `burst_len` valid cycles.
  - Continuous (`burst_len`=0): run until `stop`.
  - `stop` in either mode -> DONE; the cycle in which `stop` is sampled carries no valid.
- DONE: `done`=1, `enc_en`=0 (without config macro), `sample_valid`=0, for one cycle; then IDLE.
- `start` outside IDLE is ignored; it is not queued.
- Changes to `burst_len` after acceptance have no effect.

## Timing
- `start` sampled at edge T -> at T+1, `busy`=1 and `enc_en`=1.
- First `sample_valid` at T+1+WARMUP_CYCLES.
- Last valid at T+WARMUP_CYCLES+`burst_len`.
- `done` at T+WARMUP_CYCLES+`burst_len`+1; `busy` still 1 in that cycle and 0 the cycle after.
- Earliest next accepted `start`: the cycle after `done`.
- `stop` sampled at edge S in CAPTURE -> `sample_valid`=0 and `done`=1 at S+1.
- `sample_count` is updated in the same cycle as the `sample_valid` it counts.

## Configuration
- `SYZYGY_ADC_ENC_CTRL_FREE_RUN_EN` undefined:
  - Encode is gated; `enc_en` is 1 only in WARMUP and CAPTURE.
  - Every burst pays WARMUP_CYCLES.
- Defined:
  - `enc_en` rises the first cycle after reset deasserts and stays 1 until the next reset.
  - WARMUP runs once after reset with `busy`=1; a `start` during it is ignored.
  - Later bursts go IDLE -> CAPTURE directly, so the first valid is at T+1.
  - `done`/`stop` semantics are unchanged.

## Structure
- Package `syzygy_adc_pkg`: state enum `adc_enc_state_t` (IDLE, WARMUP, CAPTURE, DONE); constant `ADC_ENC_WARMUP_DEFAULT`=16.
- Single module. No sub-module; the warmup and sample counters are inline.
- The existing encode output buffer wrapper stays separate and is fed through a clock buffer enabled by `enc_en`.

## Test plan
- WARMUP_CYCLES=4, `burst_len`=3, pulse `start` at T:
  - `enc_en` at T+1; valid at T+5..T+7.
  - `done` at T+8; `sample_count`=3; `enc_en`=0 at T+8.
- `burst_len`=0, `start`, assert `stop` 10 cycles after first valid:
  - exactly 10 valids; `done` the next cycle; `sample_count`=10.
- `stop` during WARMUP:
  - return to IDLE; `done` never pulses; `sample_count`=0; `enc_en` falls the next cycle.
- `start` held high through an entire burst:
  - exactly one burst runs; a second burst begins the cycle after `done`.
- `reset` asserted mid-CAPTURE:
  - all outputs 0 the next cycle; no `done`.
- With the FREE_RUN macro defined:
  - `enc_en`=1 from reset+1.
  - After initial WARMUP, `start` at T gives first valid at T+1.
